// File: rtl/gpr_write_arbiter_pkg.sv
// Shared types and constants for the GPR write-back arbiter.
// Register-file geometry, architectural index constants and the write-entry record.
package gpr_write_arbiter_pkg;

  localparam int unsigned REG_N      = 18;
  localparam int unsigned REG_IDX_W  = $clog2(REG_N);
  localparam int unsigned GPR_DATA_W = 64;

  localparam logic [REG_IDX_W-1:0] REG_RSP = 5'd4;
  localparam logic [REG_IDX_W-1:0] REG_RBP = 5'd5;
  localparam logic [REG_IDX_W-1:0] REG_RIP = 5'd16;
  localparam logic [REG_IDX_W-1:0] REG_EFL = 5'd17;

  // Data field is sized for the widest supported datapath; narrower DATA_W zero-extends.
  typedef struct packed {
    logic [REG_IDX_W-1:0]  dst;
    logic [GPR_DATA_W-1:0] data;
  } gpr_wr_t;

  function automatic logic [REG_N-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    logic [REG_N-1:0] oh;
    oh = '0;
    for (int unsigned r = 0; r < REG_N; r++) begin
      oh[r] = (idx == REG_IDX_W'(r));
    end
    return oh;
  endfunction

endpackage

// File: rtl/gpr_write_arbiter_if.sv
// Producer/consumer signal bundle for the GPR write arbiter.
// master = the side driving execute/load results; slave = the arbiter.
interface gpr_write_arbiter_if
  import gpr_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = GPR_DATA_W
) ();

  logic                 ex_valid;
  logic                 ex_ready;
  logic [REG_IDX_W-1:0] ex_dst;
  logic [DATA_W-1:0]    ex_data;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [REG_IDX_W-1:0] ld_dst;
  logic [DATA_W-1:0]    ld_data;
  logic                 flush;
  logic                 gpr_we;
  logic [REG_IDX_W-1:0] gpr_waddr;
  logic [DATA_W-1:0]    gpr_wdata;
  logic [REG_N-1:0]     busy_mask;

  modport master (
    output ex_valid, ex_dst, ex_data, ld_valid, ld_dst, ld_data, flush,
    input  ex_ready, ld_ready, gpr_we, gpr_waddr, gpr_wdata, busy_mask
  );

  modport slave (
    input  ex_valid, ex_dst, ex_data, ld_valid, ld_dst, ld_data, flush,
    output ex_ready, ld_ready, gpr_we, gpr_waddr, gpr_wdata, busy_mask
  );

endinterface

// File: rtl/gpr_write_arbiter_wb_result_fifo.sv
// Circular FIFO buffering execute-stage results awaiting the GPR write port.
// Exposes per-entry valid/dst so the parent can build the pending-write mask.
module gpr_write_arbiter_wb_result_fifo
  import gpr_write_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_push,
  input  gpr_wr_t                          i_entry,
  input  logic                             i_pop,
  input  logic                             i_flush,
  output gpr_wr_t                          o_head,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [CNT_W-1:0]                 o_count,
  output logic [DEPTH-1:0]                 o_valid,
  output logic [DEPTH-1:0][REG_IDX_W-1:0]  o_dst
);

  gpr_wr_t              r_mem [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;

  // Storage carries no reset; r_valid alone decides whether an entry exists.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wptr] <= i_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr          <= r_wptr + PTR_W'(1);
        r_valid[r_wptr] <= 1'b1;
      end
      if (i_pop) begin
        r_rptr          <= r_rptr + PTR_W'(1);
        r_valid[r_rptr] <= 1'b0;
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_valid = r_valid;

  always_comb begin
    o_dst = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_dst[i] = r_mem[i].dst;
    end
  end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Shares the single GPR write port between load returns (default winners) and
// buffered execute results, with a streak limiter guaranteeing execute progress.
module gpr_write_arbiter
  import gpr_write_arbiter_pkg::*;
#(
  parameter  int unsigned EX_BUF_DEPTH  = 2,
  parameter  int unsigned MAX_LD_STREAK = 4,
  parameter  int unsigned DATA_W        = GPR_DATA_W,
  localparam int unsigned STREAK_W      = $clog2(MAX_LD_STREAK + 1),
  localparam int unsigned CNT_W         = $clog2(EX_BUF_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  gpr_write_arbiter_if.slave  bus,
  output logic [STREAK_W-1:0] ld_streak_o
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LD_STREAK);

  logic                                   w_full;
  logic                                   w_empty;
  logic                                   w_nonempty;
  logic [CNT_W-1:0]                       w_count;
  logic                                   w_push;
  logic                                   w_force_ex;
  logic                                   w_ld_grant;
  logic                                   w_ex_grant;
  gpr_wr_t                                w_ex_entry;
  gpr_wr_t                                w_head;
  gpr_wr_t                                w_win;
  logic [EX_BUF_DEPTH-1:0]                w_valid;
  logic [EX_BUF_DEPTH-1:0][REG_IDX_W-1:0] w_dst;
  logic [REG_N-1:0]                       w_busy;
  logic [STREAK_W-1:0]                    w_streak_d;
  logic [STREAK_W-1:0]                    r_streak;
  logic                                   r_we;
  gpr_wr_t                                r_out;

  assign w_nonempty = (w_count != '0);
  assign w_force_ex = w_nonempty && (r_streak == STREAK_MAX);

  // Readies are gated by rstn so nothing handshakes while the block is held in reset.
  assign bus.ex_ready = rstn && !w_full && !bus.flush;
  assign bus.ld_ready = rstn && !w_force_ex;

  assign w_push     = bus.ex_valid && bus.ex_ready;
  assign w_ld_grant = bus.ld_valid && bus.ld_ready;
  assign w_ex_grant = !w_ld_grant && w_nonempty && !bus.flush;

  always_comb begin
    w_ex_entry      = '0;
    w_ex_entry.dst  = bus.ex_dst;
    w_ex_entry.data = GPR_DATA_W'(bus.ex_data);
    w_win           = w_head;
    if (w_ld_grant) begin
      w_win.dst  = bus.ld_dst;
      w_win.data = GPR_DATA_W'(bus.ld_data);
    end
  end

  gpr_write_arbiter_wb_result_fifo #(
    .DEPTH (EX_BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_entry (w_ex_entry),
    .i_pop   (w_ex_grant),
    .i_flush (bus.flush),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_dst   (w_dst)
  );

  // Streak only measures how long a non-empty FIFO has been starved.
  always_comb begin
    w_streak_d = r_streak;
    if (bus.flush || w_ex_grant || !w_nonempty) begin
      w_streak_d = '0;
    end else if (w_ld_grant && (r_streak != STREAK_MAX)) begin
      w_streak_d = r_streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_streak <= '0;
      r_we     <= 1'b0;
      r_out    <= '0;
    end else begin
      r_streak <= w_streak_d;
      r_we     <= w_ld_grant || w_ex_grant;
      if (w_ld_grant || w_ex_grant) begin
        r_out <= w_win;
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int unsigned i = 0; i < EX_BUF_DEPTH; i++) begin
      if (w_valid[i]) begin
        w_busy = w_busy | reg_onehot(w_dst[i]);
      end
    end
  end

  assign bus.gpr_we    = r_we;
  assign bus.gpr_waddr = r_out.dst;
  assign bus.gpr_wdata = r_out.data[DATA_W-1:0];
  assign bus.busy_mask = w_busy;
  assign ld_streak_o   = r_streak;

  assert property (@(posedge clk) disable iff (!rstn) w_empty == (w_count == '0));
  assert property (@(posedge clk) disable iff (!rstn) !(w_push && w_full));

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed bench for gpr_write_arbiter: single write, load-streak limiting,
// flush, pointer wrap and asynchronous reset with a full buffer.
module tb_gpr_write_arbiter;
  import gpr_write_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] ld_streak;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  gpr_write_arbiter_if #(.DATA_W(64)) bus ();

  gpr_write_arbiter #(
    .EX_BUF_DEPTH  (2),
    .MAX_LD_STREAK (4),
    .DATA_W        (64)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus.slave),
    .ld_streak_o (ld_streak)
  );

  // Streak scenario: ex offered cycles 0..10, loads cycles 1..10, drain in 11..12.
  int          exp_exr   [13] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
  int          exp_ldr   [13] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
  int          exp_we    [13] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int          exp_addr  [13] = '{3, 3, 1, 2, 3, 4, 10, 5, 6, 7, 8, 11, 12};
  int          exp_stk   [13] = '{0, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 0};
  logic [63:0] exp_data  [13] = '{64'h1234, 64'h1234, 64'hA000, 64'hA001, 64'hA002,
                                  64'hA003, 64'hE000, 64'hA004, 64'hA005, 64'hA006,
                                  64'hA007, 64'hE001, 64'hE002};

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid = 1'b0;
    bus.ld_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic drive_ex(input int dst, input logic [63:0] data);
    bus.ex_valid = 1'b1;
    bus.ex_dst   = REG_IDX_W'(dst);
    bus.ex_data  = data;
  endtask

  task automatic drive_ld(input int dst, input logic [63:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_dst   = REG_IDX_W'(dst);
    bus.ld_data  = data;
  endtask

  initial begin
    int ex_i;
    int ld_j;
    rstn = 1'b0;
    idle();
    bus.ex_dst  = '0;
    bus.ex_data = '0;
    bus.ld_dst  = '0;
    bus.ld_data = '0;

    #2;
    chk_eq("rst_we", bus.gpr_we, 0);
    chk_eq("rst_waddr", bus.gpr_waddr, 0);
    chk_eq("rst_wdata", bus.gpr_wdata, 0);
    chk_eq("rst_busy", bus.busy_mask, 0);
    chk_eq("rst_ex_ready", bus.ex_ready, 0);
    chk_eq("rst_ld_ready", bus.ld_ready, 0);
    chk_eq("rst_streak", ld_streak, 0);
    cyc();
    rstn = 1'b1;

    // Single execute result
    cyc();
    drive_ex(3, 64'h1234);
    #1;
    chk_eq("single_ex_ready", bus.ex_ready, 1);
    cyc();
    idle();
    #1;
    chk_eq("single_busy", bus.busy_mask, 64'h8);
    chk_eq("single_we_early", bus.gpr_we, 0);
    cyc();
    #1;
    chk_eq("single_we", bus.gpr_we, 1);
    chk_eq("single_waddr", bus.gpr_waddr, 3);
    chk_eq("single_wdata", bus.gpr_wdata, 64'h1234);
    chk_eq("single_busy_clr", bus.busy_mask, 0);
    cyc();
    #1;
    chk_eq("single_we_off", bus.gpr_we, 0);
    chk_eq("single_waddr_hold", bus.gpr_waddr, 3);
    chk_eq("single_wdata_hold", bus.gpr_wdata, 64'h1234);

    // Fill FIFO under continuous loads: L,L,L,L,E,L,L,L,L,E then drain
    ex_i = 0;
    ld_j = 0;
    for (int c = 0; c < 13; c++) begin
      cyc();
      idle();
      if (c <= 10) drive_ex(10 + ex_i, 64'hE000 + 64'(ex_i));
      if (c >= 1 && c <= 10) drive_ld(1 + ld_j, 64'hA000 + 64'(ld_j));
      #1;
      chk_eq($sformatf("fill_ex_ready[%0d]", c), bus.ex_ready, 64'(exp_exr[c]));
      chk_eq($sformatf("fill_ld_ready[%0d]", c), bus.ld_ready, 64'(exp_ldr[c]));
      chk_eq($sformatf("fill_we[%0d]", c), bus.gpr_we, 64'(exp_we[c]));
      chk_eq($sformatf("fill_waddr[%0d]", c), bus.gpr_waddr, 64'(exp_addr[c]));
      chk_eq($sformatf("fill_wdata[%0d]", c), bus.gpr_wdata, exp_data[c]);
      chk_eq($sformatf("fill_streak[%0d]", c), ld_streak, 64'(exp_stk[c]));
      if (bus.ex_valid && bus.ex_ready) ex_i++;
      if (bus.ld_valid && bus.ld_ready) ld_j++;
    end
    idle();

    // Flush with dst 5 and 7 buffered, concurrent load to dst 9
    cyc();
    drive_ex(5, 64'h5555);
    drive_ld(1, 64'hB001);
    #1;
    chk_eq("flush_push5_ready", bus.ex_ready, 1);
    cyc();
    drive_ex(7, 64'h7777);
    drive_ld(2, 64'hB002);
    #1;
    chk_eq("flush_push7_ready", bus.ex_ready, 1);
    cyc();
    drive_ex(8, 64'h8888);
    drive_ld(9, 64'hB009);
    bus.flush = 1'b1;
    #1;
    chk_eq("flush_ex_ready", bus.ex_ready, 0);
    chk_eq("flush_ld_ready", bus.ld_ready, 1);
    chk_eq("flush_busy_pre", bus.busy_mask, 64'hA0);
    chk_eq("flush_streak_pre", ld_streak, 1);
    chk_eq("flush_prev_waddr", bus.gpr_waddr, 2);
    cyc();
    idle();
    #1;
    chk_eq("flush_busy_post", bus.busy_mask, 0);
    chk_eq("flush_ld_we", bus.gpr_we, 1);
    chk_eq("flush_ld_waddr", bus.gpr_waddr, 9);
    chk_eq("flush_ld_wdata", bus.gpr_wdata, 64'hB009);
    chk_eq("flush_streak_post", ld_streak, 0);
    cyc();
    #1;
    chk_eq("flush_no_ex_we0", bus.gpr_we, 0);
    cyc();
    #1;
    chk_eq("flush_no_ex_we1", bus.gpr_we, 0);
    chk_eq("flush_waddr_hold", bus.gpr_waddr, 9);

    // Wrap-around: ten back-to-back pushes, no loads
    for (int c = 0; c < 12; c++) begin
      cyc();
      idle();
      if (c < 10) drive_ex(c, 64'hC000 + 64'(c));
      #1;
      if (c < 10) chk_eq($sformatf("wrap_ex_ready[%0d]", c), bus.ex_ready, 1);
      if (c >= 1 && c <= 10) begin
        chk_eq($sformatf("wrap_busy[%0d]", c), bus.busy_mask, 64'(1) << (c - 1));
      end
      if (c >= 2) begin
        chk_eq($sformatf("wrap_we[%0d]", c), bus.gpr_we, 1);
        chk_eq($sformatf("wrap_waddr[%0d]", c), bus.gpr_waddr, 64'(c - 2));
        chk_eq($sformatf("wrap_wdata[%0d]", c), bus.gpr_wdata, 64'hC000 + 64'(c - 2));
      end else begin
        chk_eq($sformatf("wrap_we[%0d]", c), bus.gpr_we, 0);
      end
    end
    idle();
    cyc();
    #1;
    chk_eq("wrap_we_end", bus.gpr_we, 0);
    chk_eq("wrap_busy_end", bus.busy_mask, 0);

    // Async reset mid-cycle with a full FIFO
    cyc();
    drive_ex(2, 64'h2222);
    drive_ld(1, 64'hD001);
    cyc();
    drive_ex(4, 64'h4444);
    drive_ld(3, 64'hD003);
    cyc();
    bus.ex_valid = 1'b0;
    drive_ld(14, 64'hD00E);
    #1;
    chk_eq("arst_busy_pre", bus.busy_mask, 64'h14);
    chk_eq("arst_full_ready", bus.ex_ready, 0);
    chk_eq("arst_we_pre", bus.gpr_we, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk_eq("arst_we", bus.gpr_we, 0);
    chk_eq("arst_busy", bus.busy_mask, 0);
    chk_eq("arst_waddr", bus.gpr_waddr, 0);
    chk_eq("arst_ex_ready", bus.ex_ready, 0);
    chk_eq("arst_ld_ready", bus.ld_ready, 0);
    chk_eq("arst_streak", ld_streak, 0);
    idle();
    cyc();
    cyc();
    rstn = 1'b1;
    #1;
    chk_eq("arst_rel_we", bus.gpr_we, 0);
    cyc();
    drive_ex(6, 64'hD006);
    #1;
    chk_eq("arst_push_ready", bus.ex_ready, 1);
    cyc();
    idle();
    #1;
    chk_eq("arst_push_busy", bus.busy_mask, 64'h40);
    chk_eq("arst_push_we_early", bus.gpr_we, 0);
    cyc();
    #1;
    chk_eq("arst_push_we", bus.gpr_we, 1);
    chk_eq("arst_push_waddr", bus.gpr_waddr, 6);
    chk_eq("arst_push_wdata", bus.gpr_wdata, 64'hD006);
    cyc();
    #1;
    chk_eq("arst_push_we_off", bus.gpr_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
